// File: rtl/spi_arbiter_pkg.sv
// Shared types and defaults for the SPI master arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Word returned to the owner when the SPI master never answers
    localparam logic [31:0] SPI_ARB_ERR_WORD    = 32'hDEAD_DEAD;
    localparam int          SPI_ARB_NUM_REQ     = 4;
    localparam int          SPI_ARB_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
// Shared by other peripheral arbiters, so it carries no state of its own.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] cand(input logic [IW-1:0] l, input int off);
        return IW'((int'(l) + off) % N);
    endfunction

    // Scan offsets from far to near so the nearest requester after 'last' wins
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = N; off >= 1; off--) begin
            if (req[cand(last, off)]) begin
                grant                 = '0;
                grant[cand(last, off)] = 1'b1;
                idx                   = cand(last, off);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among NUM_REQ requesters.
// One 32-bit transfer at a time; grant_bo doubles as the chip-select demux select.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a stuck transfer after
// TIMEOUT_CYC cycles in WAIT with err_o and the error word.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = SPI_ARB_NUM_REQ,
    parameter int TIMEOUT_CYC = SPI_ARB_TIMEOUT_CYC
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_bi,
    input  logic [NUM_REQ*32-1:0] data_bi,
    output logic [NUM_REQ-1:0]    ack_bo,
    output logic [31:0]           rx_data_bo,
    output logic                  err_o,
    output logic [NUM_REQ-1:0]    grant_bo,
    output logic                  busy_o,
    output logic [31:0]           data_tx_bo,
    output logic                  data_tx_wr_o,
    input  logic [31:0]           data_rx_bi,
    input  logic                  data_rx_wr_i,
    input  logic                  spi_busy_i
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("spi_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_t         r_state;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic [31:0]        r_tx;
    logic [31:0]        r_rx;
    logic               r_err;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IW-1:0]      w_pick_idx;
    logic [31:0]        w_slice [NUM_REQ];
    logic               w_timeout;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice[g] = data_bi[g*32 +: 32];
    end

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_bi),
        .last  (r_last),
        .grant (w_pick_grant),
        .idx   (w_pick_idx)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_wd;

    // Watchdog counts cycles spent in WAIT; zero everywhere else (so ISSUE clears it)
    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != ST_WAIT) r_wd <= '0;
        else                             r_wd <= r_wd + 1'b1;
    end

    // Fires on the TIMEOUT_CYC-th WAIT cycle, so ack lands TIMEOUT_CYC+1 after ISSUE
    assign w_timeout = (r_state == ST_WAIT) && (r_wd == CW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Transfer sequencer: arbitrate, issue the word, await the reply, acknowledge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_last  <= IW'(NUM_REQ - 1);
            r_owner <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_bi && !spi_busy_i) begin
                        r_grant <= w_pick_grant;
                        r_owner <= w_pick_idx;
                        r_tx    <= w_slice[w_pick_idx];
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    // A real reply beats a coincident timeout
                    if (data_rx_wr_i) begin
                        r_rx    <= data_rx_bi;
                        r_ack   <= r_grant;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_rx    <= SPI_ARB_ERR_WORD;
                        r_ack   <= r_grant;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_owner;
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack_bo       = r_ack;
    assign rx_data_bo   = r_rx;
    assign err_o        = r_err;
    assign grant_bo     = r_grant;
    assign data_tx_bo   = r_tx;
    assign data_tx_wr_o = (r_state == ST_ISSUE);
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter; the bench plays the spi_master side.
// Builds with or without SPI_ARB_TIMEOUT_EN (uses TIMEOUT_CYC=16 when defined).
module tb_spi_arbiter;

    localparam int NR = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [NR-1:0]  req_bi;
    logic [NR*32-1:0] data_bi;
    logic [NR-1:0]  ack_bo;
    logic [31:0]    rx_data_bo;
    logic           err_o;
    logic [NR-1:0]  grant_bo;
    logic           busy_o;
    logic [31:0]    data_tx_bo;
    logic           data_tx_wr_o;
    logic [31:0]    data_rx_bi;
    logic           data_rx_wr_i;
    logic           spi_busy_i;

    spi_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_bi(req_bi), .data_bi(data_bi),
        .ack_bo(ack_bo), .rx_data_bo(rx_data_bo), .err_o(err_o),
        .grant_bo(grant_bo), .busy_o(busy_o), .data_tx_bo(data_tx_bo),
        .data_tx_wr_o(data_tx_wr_o), .data_rx_bi(data_rx_bi),
        .data_rx_wr_i(data_rx_wr_i), .spi_busy_i(spi_busy_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_last;              // model: last owner
    logic [31:0] m_data [NR];         // model: per-requester tx words
    logic [31:0] m_rx;                // model: last word returned
    int          ack_cnt [NR];
    logic [NR-1:0] g_obs;             // grant seen in the latest transfer

    // Spec rule: first requester at last+1, last+2, ... mod NR
    function automatic int rr_pick(input logic [NR-1:0] m, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (((m >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_data();
        for (int k = 0; k < NR; k++) data_bi[k*32 +: 32] = m_data[2'(k)];
    endtask

    task automatic apply_reset();
        rst_i = 1'b1; req_bi = '0; data_rx_wr_i = 1'b0; spi_busy_i = 1'b0;
        tick();
        rst_i  = 1'b0;
        m_last = NR - 1;
        m_rx   = 32'h0;
    endtask

    // Called in an IDLE cycle with req_bi already set; returns in the next IDLE cycle
    task automatic xfer(input int lat, input bit drop, input logic [31:0] rxw);
        int exp;
        exp = rr_pick(req_bi, m_last);
        tick();
        g_obs = grant_bo;
        n_checks++;
        if (grant_bo !== 4'(1 << exp)) begin
            n_fail++; $display("FAIL grant: got %b want %b", grant_bo, 4'(1 << exp));
        end
        n_checks++;
        if ({data_tx_wr_o, busy_o, data_tx_bo} !== {1'b1, 1'b1, m_data[2'(exp)]}) begin
            n_fail++; $display("FAIL issue: wr=%b busy=%b tx=%h want wr=1 busy=1 tx=%h",
                               data_tx_wr_o, busy_o, data_tx_bo, m_data[2'(exp)]);
        end
        tick();
        if (drop) req_bi = req_bi & ~4'(1 << exp);
        repeat (lat) tick();
        n_checks++;
        if ({data_tx_wr_o, ack_bo, busy_o} !== {1'b0, 4'b0, 1'b1}) begin
            n_fail++; $display("FAIL wait: wr=%b ack=%b busy=%b want 0 0000 1",
                               data_tx_wr_o, ack_bo, busy_o);
        end
        data_rx_bi = rxw; data_rx_wr_i = 1'b1;
        tick();
        data_rx_wr_i = 1'b0; data_rx_bi = $urandom;
        for (int k = 0; k < NR; k++) if (((ack_bo >> k) & 4'd1) != 4'd0) ack_cnt[2'(k)]++;
        n_checks++;
        if ({ack_bo, rx_data_bo, err_o} !== {4'(1 << exp), rxw, 1'b0}) begin
            n_fail++; $display("FAIL ack: ack=%b rx=%h err=%b want %b %h 0",
                               ack_bo, rx_data_bo, err_o, 4'(1 << exp), rxw);
        end
        m_last = exp;
        m_rx   = rxw;
        tick();
        n_checks++;
        if ({ack_bo, grant_bo, busy_o, rx_data_bo} !== {4'b0, 4'b0, 1'b0, m_rx}) begin
            n_fail++; $display("FAIL post_done: ack=%b grant=%b busy=%b rx=%h want 0 0 0 %h",
                               ack_bo, grant_bo, busy_o, rx_data_bo, m_rx);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_bi = '0; data_rx_wr_i = 1'b0; spi_busy_i = 1'b0;
        data_rx_bi = '0; data_bi = '0;
        tick(); tick();
        rst_i = 1'b0; m_last = NR - 1; m_rx = '0;
        n_checks++;
        if ({grant_bo, ack_bo, busy_o, data_tx_wr_o, err_o, rx_data_bo, data_tx_bo} !== '0) begin
            n_fail++; $display("FAIL reset: grant=%b ack=%b busy=%b wr=%b err=%b rx=%h tx=%h want all 0",
                               grant_bo, ack_bo, busy_o, data_tx_wr_o, err_o, rx_data_bo, data_tx_bo);
        end
    endtask

    task automatic test_single();
        apply_reset();
        m_data[0] = 32'h1234_5678; set_data();
        req_bi = 4'b0001;
        xfer(2, 1'b0, 32'hA5A5_0001);
        req_bi = '0;
    endtask

    // All four held: order 0,1,2,3,0 and next grant only at M+3 (checked inside xfer)
    task automatic test_back_to_back();
        int ord [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int k = 0; k < NR; k++) begin m_data[2'(k)] = $urandom; ack_cnt[2'(k)] = 0; end
        set_data();
        req_bi = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            xfer($urandom_range(0, 3), 1'b0, $urandom);
            n_checks++;
            if (g_obs !== 4'(1 << ord[i])) begin
                n_fail++; $display("FAIL fair_order[%0d]: got %b want %b", i, g_obs, 4'(1 << ord[i]));
            end
            if (i == 3) begin
                for (int k = 0; k < NR; k++) begin
                    n_checks++;
                    if (ack_cnt[2'(k)] !== 1) begin
                        n_fail++; $display("FAIL fair_acks[%0d]: got %0d want 1", k, ack_cnt[2'(k)]);
                    end
                end
            end
        end
        req_bi = '0;
        tick();
    endtask

    task automatic test_busy();
        apply_reset();
        m_data[2] = $urandom; set_data();
        spi_busy_i = 1'b1; req_bi = 4'b0100;
        repeat (5) tick();
        n_checks++;
        if ({grant_bo, busy_o, data_tx_wr_o} !== '0) begin
            n_fail++; $display("FAIL busy_gate: grant=%b busy=%b wr=%b want 0", grant_bo, busy_o, data_tx_wr_o);
        end
        spi_busy_i = 1'b0;
        xfer(1, 1'b0, $urandom);   // grant one cycle after the fall
        req_bi = '0;
    endtask

    task automatic test_stray_drop();
        data_rx_bi = 32'hBAD0_BAD0; data_rx_wr_i = 1'b1;
        tick();
        data_rx_wr_i = 1'b0;
        n_checks++;
        if ({ack_bo, busy_o, rx_data_bo} !== {4'b0, 1'b0, m_rx}) begin
            n_fail++; $display("FAIL stray_rx: ack=%b busy=%b rx=%h want 0 0 %h", ack_bo, busy_o, rx_data_bo, m_rx);
        end
        tick();
        n_checks++;
        if (ack_bo !== 4'b0) begin
            n_fail++; $display("FAIL stray_rx_late: ack=%b want 0000", ack_bo);
        end
        m_data[2] = $urandom; set_data();
        req_bi = 4'b0100;
        xfer(3, 1'b1, $urandom);   // request dropped in WAIT, ack still expected
        req_bi = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_data[2] = $urandom; set_data();
        req_bi = 4'b0100;
        tick(); tick();                        // ISSUE, then WAIT
        rst_i = 1'b1;
        tick();
        n_checks++;
        if ({grant_bo, ack_bo, busy_o, data_tx_wr_o, err_o, rx_data_bo, data_tx_bo} !== '0) begin
            n_fail++; $display("FAIL reset_mid: grant=%b ack=%b busy=%b wr=%b err=%b rx=%h tx=%h want all 0",
                               grant_bo, ack_bo, busy_o, data_tx_wr_o, err_o, rx_data_bo, data_tx_bo);
        end
        rst_i = 1'b0; m_last = NR - 1; m_rx = '0;
        for (int k = 0; k < NR; k++) m_data[2'(k)] = $urandom;
        set_data();
        req_bi = 4'b1111;
        xfer(0, 1'b0, $urandom);
        n_checks++;
        if (g_obs !== 4'b0001) begin
            n_fail++; $display("FAIL prio_after_reset: got %b want 0001", g_obs);
        end
        req_bi = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit seen_ack;
        apply_reset();
        m_data[1] = $urandom; set_data();
        req_bi = 4'b0010;
        tick();                                // ISSUE cycle
        req_bi = '0;
        seen_ack = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (TO) begin tick(); if (ack_bo !== 4'b0) seen_ack = 1'b1; end
        n_checks++;
        if (seen_ack) begin
            n_fail++; $display("FAIL timeout_early: ack seen before ISSUE+%0d", TO + 1);
        end
        tick();
        n_checks++;
        if ({ack_bo, err_o, rx_data_bo} !== {4'b0010, 1'b1, 32'hDEAD_DEAD}) begin
            n_fail++; $display("FAIL timeout: ack=%b err=%b rx=%h want 0010 1 deaddead", ack_bo, err_o, rx_data_bo);
        end
        tick();
        m_last = 1; m_rx = 32'hDEAD_DEAD;
`else
        repeat (60) begin tick(); if (ack_bo !== 4'b0 || err_o !== 1'b0) seen_ack = 1'b1; end
        n_checks++;
        if (seen_ack || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL wait_forever: ack_or_err=%b busy=%b want 0 1", seen_ack, busy_o);
        end
        data_rx_bi = 32'h0BAD_F00D; data_rx_wr_i = 1'b1;
        tick();
        data_rx_wr_i = 1'b0;
        n_checks++;
        if ({ack_bo, err_o, rx_data_bo} !== {4'b0010, 1'b0, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL late_reply: ack=%b err=%b rx=%h want 0010 0 0badf00d", ack_bo, err_o, rx_data_bo);
        end
        tick();
        m_last = 1; m_rx = 32'h0BAD_F00D;
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < NR; k++)
                if (((req_bi >> k) & 4'd1) == 4'd0) m_data[2'(k)] = $urandom;
            set_data();
            req_bi = req_bi | 4'($urandom_range(0, 15));
            if (req_bi == '0) req_bi = 4'(1 << $urandom_range(0, 3));
            xfer($urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) req_bi = req_bi & ~4'(1 << m_last);
        end
        req_bi = '0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_stray_drop();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
